// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: command, move-to/from and status signals of the HI/LO multiply/divide unit
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a, b, wdata, mfout, hi, lo;
  logic hi_we, lo_we, mf_sel, busy, done;
  modport master (output start, op, a, b, hi_we, lo_we, wdata, mf_sel, input mfout, hi, lo, busy, done);
  modport slave (input start, op, a, b, hi_we, lo_we, wdata, mf_sel, output mfout, hi, lo, busy, done);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative shift-add multiply / restoring divide unit with architectural HI/LO registers
module mdu_hilo #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  mdu_hilo_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, quo, rem;
  logic sa_q, sa_d, sb_q, sb_d, div_q, div_d, done_q, done_d, neg_a, neg_b;
  logic [WIDTH:0] msum, rem_s, diff;
  always_comb begin
    neg_a = bus.op[0] & bus.a[WIDTH-1];
    neg_b = bus.op[0] & bus.b[WIDTH-1];
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{acc_q[0]}}};
    rem_s = acc_q[2*WIDTH-1:WIDTH-1];
    diff = rem_s - {1'b0, b_q};
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d = b_q;
    sa_d = sa_q;
    sb_d = sb_q;
    div_d = div_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = RUN;
        cnt_d = '0;
        div_d = bus.op[1];
        sa_d = neg_a;
        sb_d = neg_b;
        b_d = neg_b ? -bus.b : bus.b;
        acc_d = {{WIDTH{1'b0}}, neg_a ? -bus.a : bus.a};
      end else begin
        hi_d = bus.hi_we ? bus.wdata : hi_q;
        lo_d = bus.lo_we ? bus.wdata : lo_q;
      end
    end else if (state_q == RUN) begin
      acc_d = !div_q ? {msum, acc_q[WIDTH-1:1]}
            : diff[WIDTH] ? {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
            : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      cnt_d = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : RUN;
    end else begin
      hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = !div_q ? prod[WIDTH-1:0] : (b_q == '0) ? '1 : quo;
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      div_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q <= b_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      div_q <= div_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign bus.mfout = bus.mf_sel ? hi_q : lo_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU over a fixed number of cycles.
- Also serves MTHI/MTLO writes.
- Drives `mfout` for MFHI/MFLO; the datapath muxes `mfout` onto the shift gate's ALU-result input, so this block sits directly upstream of the shift gate.

Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits and an operation takes `WIDTH` iterations.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch the operation given by `op` using `a` and `b`.
- `op`  in  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `mf_sel`  in  1  0 selects LO, 1 selects HI onto `mfout`.
- `mfout`  out  WIDTH  combinational `mf_sel ? hi : lo`, from committed registers only.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse after HI/LO are committed.

Behaviour:
- Interface: one clock, `clk`; `reset` is synchronous and active-high.
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state = IDLE.
- Reset asserted mid-operation aborts it; no partial result is committed.
- State machine:
  - IDLE: on `start`=1 at edge E0, latch operands into working registers and go to RUN with count = 0.
    - Signed ops (MULT, DIV) latch magnitudes `|a|` and `|b|` plus the two sign bits.
    - Unsigned ops (MULTU, DIVU) latch `a` and `b` unchanged with signs cleared.
  - RUN: one iteration per cycle at edges E1..E32 (count 0..31); go to FIX after count 31.
    - Multiply: shift-add; 64-bit product accumulator, one multiplier bit per cycle, LSB first.
    - Divide: restoring division; 64-bit remainder:quotient register, shift left 1, trial-subtract divisor, set quotient bit if no borrow.
  - FIX, edge E33: apply sign correction, write HI/LO, return to IDLE; `done`=1 for the following cycle only.
- Sign correction:
  - Product: two's-complement negate the 64-bit result if the sign bits differ.
  - Quotient: negate if the sign bits differ.
  - Remainder: takes the sign of the dividend.
- Commit:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Timing: `busy` is high from the cycle after E0 through the cycle before E33, 33 cycles total; it goes low in the same cycle `done` goes high.
- `start` while `busy`: ignored; no restart and no queuing.
- `hi_we`/`lo_we` while `busy`: ignored.
- `hi_we`/`lo_we` in IDLE: the selected register takes `wdata` at the edge; both strobes together write both registers.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the writes are dropped.
- Divide by zero, signed or unsigned: same 33-cycle latency, LO = 0xFFFFFFFF, HI = `a` unmodified.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, with no exception.
- `mfout` and `hi`/`lo` keep their old values throughout RUN and FIX and change only at E33 or on an MT write.
- `start` is sampled only in IDLE; a `start` held high after `done` launches a new operation at the first IDLE edge.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, `start` at E0 -> `busy` high 33 cycles; at E33 HI=0xFFFFFFFE, LO=0x00000001; `done` high exactly one cycle.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678 at E33. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- During a MULTU, pulse `start` with other operands and pulse `hi_we` with `wdata`=0xDEADBEEF -> both ignored; result matches the first op; `mfout` (`mf_sel`=1) holds the old HI until E33.
- In IDLE: `hi_we`=1 with `wdata`=0xA5A5A5A5 -> `mfout` (`mf_sel`=1) = 0xA5A5A5A5 next cycle. `start` together with `lo_we` -> op launches and LO is not written by `wdata`.
- Assert `reset` at cycle 10 of a DIV -> next cycle `hi`=`lo`=0, `busy`=0, no `done` pulse. A fresh MULTU 6*7 afterwards -> LO=42, HI=0.
